// File: rtl/memarb_pkg.sv
// Shared types for the memref port arbiter.
//   owner_t  : who currently holds the port lock (OWN_NONE when unlocked)
//   rd_tag_t : one read-return pipeline entry {valid, requester id}
package memarb_pkg;
  typedef enum logic [1:0] {
    OWN_R0   = 2'd0,
    OWN_R1   = 2'd1,
    OWN_NONE = 2'd2
  } owner_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  localparam int MAX_RD_LATENCY = 4;
endpackage

// File: rtl/memarb_rd_return.sv
// Read-return tag pipeline. Carries {valid, id} for every issued read for
// exactly RD_LATENCY cycles so the tag lines up with the memory's read data.
//   clk, rst      : clock, async active-low clear (drops in-flight returns)
//   i_tag         : tag of the access issued this cycle (valid=0 for writes/idle)
//   o_rd_valid0/1 : the returning data belongs to requester 0 / 1
module memarb_rd_return
  import memarb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t i_tag,
  output logic    o_rd_valid0,
  output logic    o_rd_valid1
);
  rd_tag_t r_pipe [RD_LATENCY];
  rd_tag_t w_tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail = r_pipe[RD_LATENCY-1];

  // Gated by rst so nothing is reported while reset is asserted.
  assign o_rd_valid0 = rst & w_tail.valid & ~w_tail.id;
  assign o_rd_valid1 = rst & w_tail.valid &  w_tail.id;
endmodule

// File: rtl/memref_port_arbiter.sv
// Two-requester arbiter for the single read/write port of one memref.
// Round-robin between r0/r1, optional lock to keep the port for bursts,
// and read data routed back by a tag pipeline matching RD_LATENCY.
// Optional feature macro: ARB_STATS_EN adds 16-bit saturating stall counters
// stall_cnt0/stall_cnt1 (cycles with req=1 and gnt=0).
// Ports:
//   clk, rst                  : clock, async active-low reset
//   rK_req/lock/wr_en/addr/wr_data : requester K access request (K=0,1)
//   rK_gnt                    : K's access issued to memory this cycle
//   rK_rd_valid, rK_rd_data   : read return for K (data bus shared)
//   mem_addr/rd_en/wr_en/wr_data, mem_rd_data : memory side
module memref_port_arbiter
  import memarb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 64,
  parameter int ADDR_W     = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_lock,
  input  logic              r0_wr_en,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [WIDTH-1:0]  r0_wr_data,
  input  logic              r1_req,
  input  logic              r1_lock,
  input  logic              r1_wr_en,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [WIDTH-1:0]  r1_wr_data,
  output logic              r0_gnt,
  output logic              r0_rd_valid,
  output logic [WIDTH-1:0]  r0_rd_data,
  output logic              r1_gnt,
  output logic              r1_rd_valid,
  output logic [WIDTH-1:0]  r1_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_wr_data,
  input  logic [WIDTH-1:0]  mem_rd_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1
`endif
);
  if (ADDR_W != $clog2(SIZE)) begin : g_bad_addr_w
    $error("ADDR_W must equal clog2(SIZE)");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
    $error("RD_LATENCY out of range");
  end

  owner_t            r_owner;
  logic              r_rr;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;

  logic    w_req0_g, w_req1_g;
  logic    w_g0, w_g1, w_any, w_wr, w_lock, w_abandon;
  rd_tag_t w_tag;

  // A lock whose owner has dropped req is treated as already released, so
  // the other requester can win in that same cycle.
  always_comb begin
    w_abandon = (r_owner == OWN_R0 && !r0_req) || (r_owner == OWN_R1 && !r1_req);
    w_req0_g  = 1'b0;
    w_req1_g  = 1'b0;
    if (r_owner == OWN_R0 && r0_req) begin
      w_req0_g = 1'b1;
    end else if (r_owner == OWN_R1 && r1_req) begin
      w_req1_g = 1'b1;
    end else if (r0_req && r1_req) begin
      w_req0_g = ~r_rr;
      w_req1_g = r_rr;
    end else begin
      w_req0_g = r0_req;
      w_req1_g = r1_req;
    end
  end

  assign w_g0   = rst & w_req0_g;
  assign w_g1   = rst & w_req1_g;
  assign w_any  = w_g0 | w_g1;
  assign w_wr   = w_g1 ? r1_wr_en : r0_wr_en;
  assign w_lock = w_g1 ? r1_lock  : r0_lock;

  assign r0_gnt      = w_g0;
  assign r1_gnt      = w_g1;
  assign mem_wr_en   = w_any &  w_wr;
  assign mem_rd_en   = w_any & ~w_wr;
  // Address/data hold their last issued value while the port is idle.
  assign mem_addr    = w_any ? (w_g1 ? r1_addr : r0_addr) : r_addr;
  assign mem_wr_data = w_any ? (w_g1 ? r1_wr_data : r0_wr_data) : r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
      r_rr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_any) begin
      // Pointer always moves to the other requester; during a lock this is
      // already the non-owner, so it stays put until release.
      r_rr    <= w_g0;
      r_owner <= w_lock ? (w_g1 ? OWN_R1 : OWN_R0) : OWN_NONE;
      r_addr  <= mem_addr;
      r_wdata <= mem_wr_data;
    end else if (w_abandon) begin
      r_rr    <= (r_owner == OWN_R0);
      r_owner <= OWN_NONE;
    end
  end

  always_comb begin
    w_tag       = '0;
    w_tag.valid = mem_rd_en;
    w_tag.id    = w_g1;
  end

  memarb_rd_return #(.RD_LATENCY(RD_LATENCY)) u_rd_return (
    .clk         (clk),
    .rst         (rst),
    .i_tag       (w_tag),
    .o_rd_valid0 (r0_rd_valid),
    .o_rd_valid1 (r1_rd_valid)
  );

  assign r0_rd_data = mem_rd_data;
  assign r1_rd_data = mem_rd_data;

`ifdef ARB_STATS_EN
  logic [15:0] r_stall0, r_stall1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall0 <= '0;
      r_stall1 <= '0;
    end else begin
      if (r0_req && !w_g0 && r_stall0 != 16'hFFFF) r_stall0 <= r_stall0 + 16'd1;
      if (r1_req && !w_g1 && r_stall1 != 16'hFFFF) r_stall1 <= r_stall1 + 16'd1;
    end
  end
  assign stall_cnt0 = r_stall0;
  assign stall_cnt1 = r_stall1;
`endif
endmodule

// File: tb/tb_memref_port_arbiter.sv
// Bench for memref_port_arbiter: two instances (RD_LATENCY 1 and 3) share the
// same requester stimulus; each has its own behavioural memory.
module tb_memref_port_arbiter;
  localparam int W  = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          r0_req, r0_lock, r0_wr_en, r1_req, r1_lock, r1_wr_en;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [W-1:0]  r0_wr_data, r1_wr_data;

  logic [1:0]         g0, g1, v0, v1, rden, wren;
  logic [1:0][AW-1:0] maddr;
  logic [1:0][W-1:0]  wdata, mrd, rdd0, rdd1;
`ifdef ARB_STATS_EN
  logic [1:0][15:0]   sc0, sc1;
`endif

  memref_port_arbiter #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_wr_en(r0_wr_en), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_wr_en(r1_wr_en), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
    .r0_gnt(g0[0]), .r0_rd_valid(v0[0]), .r0_rd_data(rdd0[0]),
    .r1_gnt(g1[0]), .r1_rd_valid(v1[0]), .r1_rd_data(rdd1[0]),
    .mem_addr(maddr[0]), .mem_rd_en(rden[0]), .mem_wr_en(wren[0]), .mem_wr_data(wdata[0]),
    .mem_rd_data(mrd[0])
`ifdef ARB_STATS_EN
    , .stall_cnt0(sc0[0]), .stall_cnt1(sc1[0])
`endif
  );

  memref_port_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_wr_en(r0_wr_en), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_wr_en(r1_wr_en), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
    .r0_gnt(g0[1]), .r0_rd_valid(v0[1]), .r0_rd_data(rdd0[1]),
    .r1_gnt(g1[1]), .r1_rd_valid(v1[1]), .r1_rd_data(rdd1[1]),
    .mem_addr(maddr[1]), .mem_rd_en(rden[1]), .mem_wr_en(wren[1]), .mem_wr_data(wdata[1]),
    .mem_rd_data(mrd[1])
`ifdef ARB_STATS_EN
    , .stall_cnt0(sc0[1]), .stall_cnt1(sc1[1])
`endif
  );

  // Behavioural memories: latency 1 and latency 3.
  logic [W-1:0] mem_a [64];
  logic [W-1:0] mem_b [64];
  logic [W-1:0] pipe_a;
  logic [W-1:0] pipe_b [3];
  always @(posedge clk) begin
    if (wren[0]) mem_a[maddr[0]] <= wdata[0];
    if (rden[0]) pipe_a <= mem_a[maddr[0]];
    if (wren[1]) mem_b[maddr[1]] <= wdata[1];
    pipe_b[0] <= rden[1] ? mem_b[maddr[1]] : '0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mrd[0] = pipe_a;
  assign mrd[1] = pipe_b[2];

  // Reference model state
  typedef struct {int due; int id; logic [W-1:0] data;} ret_t;
  ret_t          qa[$], qb[$];
  logic [W-1:0]  gold [64];
  int            cyc, checks, failures, m_rr, m_own;
  logic [AW-1:0] m_last;

  // Per-cycle expectations and observations
  int                 e_g;
  logic [1:0]         e_gv;
  logic               e_rden, e_wren;
  logic [AW-1:0]      e_maddr;
  logic [1:0][1:0]    e_rv, o_gv, o_rv;
  logic [1:0][W-1:0]  e_rd, o_rd;
  logic [1:0]         o_rden, o_wren;
  logic [1:0][AW-1:0] o_maddr;

  task automatic set_req(input int k, input logic rq, input logic lk, input logic wr,
                         input logic [AW-1:0] a, input logic [W-1:0] dat);
    if (k == 0) begin
      r0_req = rq; r0_lock = lk; r0_wr_en = wr; r0_addr = a; r0_wr_data = dat;
    end else begin
      r1_req = rq; r1_lock = lk; r1_wr_en = wr; r1_addr = a; r1_wr_data = dat;
    end
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
  endtask

  // One clock: predict from the rules, sample DUTs at negedge, advance model.
  task automatic tick();
    int            oe;
    logic [AW-1:0] a;
    logic [W-1:0]  wd;
    logic          lk;
    @(negedge clk);
    e_g = -1;
    oe  = -1;
    if (rst) begin
      oe = m_own;
      if ((oe == 0 && !r0_req) || (oe == 1 && !r1_req)) oe = -1;
      if (oe >= 0)              e_g = oe;
      else if (r0_req && r1_req) e_g = m_rr;
      else if (r0_req)          e_g = 0;
      else if (r1_req)          e_g = 1;
    end
    e_gv    = (e_g == 0) ? 2'b01 : (e_g == 1) ? 2'b10 : 2'b00;
    e_wren  = (e_g >= 0) && ((e_g == 0) ? r0_wr_en : r1_wr_en);
    e_rden  = (e_g >= 0) && !e_wren;
    e_maddr = (e_g == 0) ? r0_addr : (e_g == 1) ? r1_addr : m_last;
    e_rv = '0;
    e_rd = '0;
    if (rst && qa.size() > 0 && qa[0].due == cyc) begin
      e_rv[0][qa[0].id] = 1'b1; e_rd[0] = qa[0].data; void'(qa.pop_front());
    end
    if (rst && qb.size() > 0 && qb[0].due == cyc) begin
      e_rv[1][qb[0].id] = 1'b1; e_rd[1] = qb[0].data; void'(qb.pop_front());
    end
    for (int d = 0; d < 2; d++) begin
      o_gv[d]    = {g1[d], g0[d]};
      o_rv[d]    = {v1[d], v0[d]};
      o_rd[d]    = v1[d] ? rdd1[d] : rdd0[d];
      o_rden[d]  = rden[d];
      o_wren[d]  = wren[d];
      o_maddr[d] = maddr[d];
    end
    if (!rst) begin
      m_rr = 0; m_own = -1; m_last = '0; qa.delete(); qb.delete();
    end else if (e_g >= 0) begin
      a  = (e_g == 0) ? r0_addr : r1_addr;
      wd = (e_g == 0) ? r0_wr_data : r1_wr_data;
      lk = (e_g == 0) ? r0_lock : r1_lock;
      if (e_wren) gold[a] = wd;
      else begin
        qa.push_back('{cyc + 1, e_g, gold[a]});
        qb.push_back('{cyc + 3, e_g, gold[a]});
      end
      m_last = a;
      m_rr   = 1 - e_g;
      m_own  = lk ? e_g : -1;
    end else if (m_own >= 0) begin
      m_rr  = 1 - m_own;
      m_own = -1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_req(0, 1, 1, 0, 6'd3, 32'd0);
    set_req(1, 1, 0, 1, 6'd4, 32'd9);
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_gv[d], o_rv[d], o_rden[d], o_wren[d]} !== 6'b0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got gnt=%b vld=%b rd=%b wr=%b exp all 0",
                 d, o_gv[d], o_rv[d], o_rden[d], o_wren[d]);
      end
    end
    rst = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_single_read();
    set_req(0, 1, 0, 1, 6'd5, 32'd6); tick();
    set_req(0, 1, 0, 0, 6'd5, 32'd0); tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_gv[d] !== 2'b01) begin failures++; $display("FAIL single_gnt dut%0d got=%b exp=01", d, o_gv[d]); end
    end
    idle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (o_rv[0] !== ((i == 1) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL single_vld_lat1 +%0d got=%b", i, o_rv[0]);
      end
      checks++;
      if (o_rv[1] !== ((i == 3) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL single_vld_lat3 +%0d got=%b", i, o_rv[1]);
      end
      if (i == 1) begin
        checks++;
        if (o_rd[0] !== 32'd6) begin failures++; $display("FAIL single_data_lat1 got=%0d exp=6", o_rd[0]); end
      end
      if (i == 3) begin
        checks++;
        if (o_rd[1] !== 32'd6) begin failures++; $display("FAIL single_data_lat3 got=%0d exp=6", o_rd[1]); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ev;
    logic [W-1:0] ed;
    set_req(1, 1, 0, 1, 6'd11, 32'hB1); tick(); idle();
    set_req(0, 1, 0, 1, 6'd10, 32'hA0); tick(); idle();
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        set_req(0, 1, 0, 0, 6'd10, '0);
        set_req(1, 1, 0, 0, 6'd11, '0);
      end else idle();
      tick();
      if (i < 6) begin
        checks++;
        if (o_gv[0] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || o_gv[1] !== o_gv[0]) begin
          failures++; $display("FAIL rr_gnt i=%0d got=%b/%b", i, o_gv[0], o_gv[1]);
        end
      end
      if (i >= 1 && i <= 6) begin
        ev = ((i - 1) % 2 == 0) ? 2'b01 : 2'b10;
        ed = ((i - 1) % 2 == 0) ? 32'hA0 : 32'hB1;
        checks++;
        if (o_rv[0] !== ev || o_rd[0] !== ed) begin
          failures++; $display("FAIL rr_ret_lat1 i=%0d got=%b/%h exp=%b/%h", i, o_rv[0], o_rd[0], ev, ed);
        end
      end
      if (i >= 3) begin
        ev = ((i - 3) % 2 == 0) ? 2'b01 : 2'b10;
        ed = ((i - 3) % 2 == 0) ? 32'hA0 : 32'hB1;
        checks++;
        if (o_rv[1] !== ev || o_rd[1] !== ed) begin
          failures++; $display("FAIL rr_ret_lat3 i=%0d got=%b/%h exp=%b/%h", i, o_rv[1], o_rd[1], ev, ed);
        end
      end
    end
  endtask

  task automatic test_lock_burst();
    set_req(0, 1, 0, 1, 6'd30, 32'd7); tick();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 0, 0, 6'd20, '0);
      set_req(1, 1, (i < 3), 1, 6'(i), 32'(100 + i));
      tick();
      checks++;
      if (o_gv[0] !== 2'b10 || o_gv[1] !== 2'b10) begin
        failures++; $display("FAIL lock_burst_gnt i=%0d got=%b/%b exp=10", i, o_gv[0], o_gv[1]);
      end
    end
    set_req(1, 0, 0, 0, '0, '0);
    tick();
    checks++;
    if (o_gv[0] !== 2'b01) begin failures++; $display("FAIL lock_after_gnt got=%b exp=01", o_gv[0]); end
    idle(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_a[i] !== 32'(100 + i) || mem_b[i] !== 32'(100 + i)) begin
        failures++; $display("FAIL lock_mem a=%0d got=%0d/%0d exp=%0d", i, mem_a[i], mem_b[i], 100 + i);
      end
    end
  endtask

  task automatic test_lock_abandon();
    set_req(0, 1, 1, 0, 6'd21, '0); tick();
    set_req(0, 1, 1, 0, 6'd22, '0);
    set_req(1, 1, 0, 0, 6'd23, '0);
    tick();
    checks++;
    if (o_gv[0] !== 2'b01) begin failures++; $display("FAIL lock_hold_gnt got=%b exp=01", o_gv[0]); end
    set_req(0, 0, 0, 0, '0, '0);
    tick();
    checks++;
    if (o_gv[0] !== 2'b10 || o_gv[1] !== 2'b10) begin
      failures++; $display("FAIL abandon_gnt got=%b/%b exp=10", o_gv[0], o_gv[1]);
    end
    idle(); tick();
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1, 0, 0, 6'd10, '0); tick();
    set_req(1, 1, 1, 0, 6'd11, '0); tick();
    rst = 1'b0; tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_rv[d] !== 2'b00 || o_gv[d] !== 2'b00) begin
        failures++; $display("FAIL midrst_during dut%0d vld=%b gnt=%b", d, o_rv[d], o_gv[d]);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (o_gv[0] !== 2'b01 || o_gv[1] !== 2'b01 || o_rv[1] !== 2'b00) begin
      failures++; $display("FAIL midrst_contention gnt=%b/%b vld3=%b exp 01/01/00", o_gv[0], o_gv[1], o_rv[1]);
    end
    idle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (o_rv[1] !== ((i == 3) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL midrst_lat3 +%0d got=%b", i, o_rv[1]);
      end
      if (i == 1) begin
        checks++;
        if (o_rv[0] !== 2'b01) begin failures++; $display("FAIL midrst_lat1 got=%b exp=01", o_rv[0]); end
      end
    end
  endtask

  task automatic test_random();
    int pend [2];
    for (int a = 0; a < 64; a++) begin
      set_req(0, 1, 0, 1, 6'(a), $urandom);
      tick();
    end
    idle();
    pend[0] = 0;
    pend[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (pend[k] == 0) begin
          pend[k] = ($urandom_range(0, 9) < 6) ? 1 : 0;
          set_req(k, pend[k] != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  6'($urandom_range(0, 63)), $urandom);
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_gv[d] !== e_gv) begin failures++; $display("FAIL rnd_gnt n=%0d dut%0d got=%b exp=%b", n, d, o_gv[d], e_gv); end
        checks++;
        if ({o_rden[d], o_wren[d]} !== {e_rden, e_wren}) begin
          failures++; $display("FAIL rnd_en n=%0d dut%0d got=%b%b exp=%b%b", n, d, o_rden[d], o_wren[d], e_rden, e_wren);
        end
        checks++;
        if (o_maddr[d] !== e_maddr) begin failures++; $display("FAIL rnd_addr n=%0d dut%0d got=%0d exp=%0d", n, d, o_maddr[d], e_maddr); end
        checks++;
        if (o_rv[d] !== e_rv[d]) begin failures++; $display("FAIL rnd_vld n=%0d dut%0d got=%b exp=%b", n, d, o_rv[d], e_rv[d]); end
        if (e_rv[d] != 2'b00) begin
          checks++;
          if (o_rd[d] !== e_rd[d]) begin failures++; $display("FAIL rnd_data n=%0d dut%0d got=%h exp=%h", n, d, o_rd[d], e_rd[d]); end
        end
      end
      if (e_g >= 0) pend[e_g] = 0;
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_req(0, 1, 1, 0, 6'd1, '0);
      set_req(1, 1, 0, 0, 6'd2, '0);
      tick();
    end
    set_req(0, 1, 0, 0, 6'd1, '0); tick();
    set_req(0, 0, 0, 0, '0, '0);   tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sc1[d] !== 16'd10 || sc0[d] !== 16'd0) begin
        failures++; $display("FAIL stats_10 dut%0d got cnt1=%0d cnt0=%0d exp 10/0", d, sc1[d], sc0[d]);
      end
    end
    for (int i = 0; i < 70000; i++) begin
      set_req(0, 1, 1, 0, 6'd1, '0);
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sc1[d] !== 16'hFFFF || sc0[d] !== 16'd0) begin
        failures++; $display("FAIL stats_sat dut%0d got cnt1=%0d cnt0=%0d exp 65535/0", d, sc1[d], sc0[d]);
      end
    end
    idle(); tick();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    m_rr     = 0;
    m_own    = -1;
    m_last   = '0;
    rst      = 1'b0;
    idle();
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_burst();
    test_lock_abandon();
    test_reset_midflight();
    test_random();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
